// File: rtl/core_dmem_responder.sv
// core_dmem_responder: memory-side responder for the core data port.
// Byte/half/word reads and writes on an internal word-organised RAM.
// There is one outstanding request at a time. The response comes back
// LATENCY+1 cycles after the request is accepted.
// Optional feature macro: DMEM_ERR_EN adds o_data_err. It flags misaligned
// or out-of-range accesses.
module core_dmem_responder #(
   parameter int XLEN    = 32,
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 0
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [XLEN-1:0] i_data_addr,
   input  logic [XLEN-1:0] i_data_wr_data,
   input  logic [1:0]      i_data_mask,
   input  logic            i_data_wr_en,
   input  logic            i_data_req,
   output logic [XLEN-1:0] o_data_rd_data,
   output logic            o_data_ack,
   output logic            o_busy
`ifdef DMEM_ERR_EN
   ,
   output logic            o_data_err
`endif
);

   localparam int AW     = $clog2(DEPTH);
   localparam int NB     = XLEN / 8;
   localparam int LAT_M1 = (LATENCY > 0) ? LATENCY - 1 : 0;
   localparam int CW     = (LAT_M1 > 0) ? $clog2(LAT_M1 + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t            r_state, w_state_nxt;
   logic [CW-1:0]     r_cnt, w_cnt_nxt;

   // Request captured at accept; only consumed when the access happens out of WAIT
   logic [XLEN-1:0]   r_addr, r_wdata;
   logic [1:0]        r_size;
   logic              r_we;

   logic [XLEN-1:0]   r_mem [DEPTH];
   logic [XLEN-1:0]   r_rd_data;
   logic              r_ack;
   logic              r_err;

   logic              w_accept;
   logic              w_access;
   logic [XLEN-1:0]   w_op_addr, w_op_wdata;
   logic [1:0]        w_op_size;
   logic              w_op_we;
   logic [1:0]        w_off_al;
   logic [AW-1:0]     w_idx;
   logic [NB-1:0]     w_be;
   logic [XLEN-1:0]   w_wdata_sh;
   logic [XLEN-1:0]   w_rword_sh;
   logic [XLEN-1:0]   w_rd_mask;
   logic              w_err;

   assign w_accept = i_data_req && (r_state != S_WAIT);

   // With zero latency the RAM is accessed on the accept edge itself. In that
   // case the live inputs are used. Coming out of WAIT, the latched copy is used.
   assign w_op_addr  = (r_state == S_WAIT) ? r_addr  : i_data_addr;
   assign w_op_wdata = (r_state == S_WAIT) ? r_wdata : i_data_wr_data;
   assign w_op_size  = (r_state == S_WAIT) ? r_size  : i_data_mask;
   assign w_op_we    = (r_state == S_WAIT) ? r_we    : i_data_wr_en;

   assign w_idx = w_op_addr[AW+1:2];

`ifdef DMEM_ERR_EN
   logic w_misalign, w_oor;
   assign w_misalign = ((w_op_size == 2'b01) && w_op_addr[0]) ||
                       (w_op_size[1] && (w_op_addr[1:0] != 2'b00));
   assign w_oor      = |w_op_addr[XLEN-1:AW+2];
   assign w_err      = w_misalign || w_oor;
`else
   // Upper address bits wrap; they deliberately play no part in the access
   logic w_unused_addr;
   assign w_unused_addr = ^w_op_addr[XLEN-1:AW+2];
   assign w_err         = 1'b0;
`endif

   // Byte lane and enables, with natural alignment forced by size
   always_comb begin
      w_off_al  = 2'b00;
      w_be      = '1;
      w_rd_mask = '1;
      case (w_op_size)
         2'b00: begin
            w_off_al  = w_op_addr[1:0];
            w_be      = NB'(1) << w_off_al;
            w_rd_mask = XLEN'(8'hFF);
         end
         2'b01: begin
            w_off_al  = {w_op_addr[1], 1'b0};
            w_be      = NB'(3) << w_off_al;
            w_rd_mask = XLEN'(16'hFFFF);
         end
         default: begin
            w_off_al  = 2'b00;
            w_be      = '1;
            w_rd_mask = '1;
         end
      endcase
   end

   assign w_wdata_sh = w_op_wdata << {w_off_al, 3'b000};
   assign w_rword_sh = r_mem[w_idx] >> {w_off_al, 3'b000};

   // Next-state and wait-counter logic
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE, S_RESP: begin
            if (w_accept) begin
               if (LATENCY == 0) begin
                  w_state_nxt = S_RESP;
               end else begin
                  w_state_nxt = S_WAIT;
                  w_cnt_nxt   = CW'(LAT_M1);
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_WAIT: begin
            if (r_cnt == '0) w_state_nxt = S_RESP;
            else             w_cnt_nxt   = r_cnt - 1'b1;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // RESP is only ever entered together with a RAM access
   assign w_access = (w_state_nxt == S_RESP);

   // State register and wait counter
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Capture the request on accept
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_size  <= '0;
         r_we    <= 1'b0;
      end else if (w_accept) begin
         r_addr  <= i_data_addr;
         r_wdata <= i_data_wr_data;
         r_size  <= i_data_mask;
         r_we    <= i_data_wr_en;
      end
   end

   // RAM byte writes; RAM contents are never reset
   always_ff @(posedge i_clk) begin
      if (!i_rst && w_access && w_op_we && !w_err) begin
         for (int b = 0; b < NB; b++) begin
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
         end
      end
   end

   // Response registers: ack pulse, held read data, error flag
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ack     <= 1'b0;
         r_rd_data <= '0;
         r_err     <= 1'b0;
      end else begin
         r_ack <= w_access;
         r_err <= w_access && w_err;
         if (w_access) begin
            if (w_err)        r_rd_data <= '0;
            else if (!w_op_we) r_rd_data <= w_rword_sh & w_rd_mask;
         end
      end
   end

   assign o_data_ack     = r_ack;
   assign o_data_rd_data = r_rd_data;
   assign o_busy         = (r_state == S_WAIT);
`ifdef DMEM_ERR_EN
   assign o_data_err     = r_err;
`else
   logic w_unused_err;
   assign w_unused_err = r_err;
`endif

endmodule

// File: tb/tb_core_dmem_responder.sv
// Bench for core_dmem_responder. There are two instances, LATENCY=0 and LATENCY=3.
// Each is checked against a byte-addressed reference memory model.
module tb_core_dmem_responder;
   localparam int DEPTH  = 256;
   localparam int NBYTES = 4 * DEPTH;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst0, req0, we0, ack0, busy0;
   logic [1:0]  sz0;
   logic [31:0] a0, wd0, rd0;
   logic        rst3, req3, we3, ack3, busy3;
   logic [1:0]  sz3;
   logic [31:0] a3, wd3, rd3;
`ifdef DMEM_ERR_EN
   logic        err0, err3;
`endif

   core_dmem_responder #(.XLEN(32), .DEPTH(DEPTH), .LATENCY(0)) dut0 (
      .i_clk(clk), .i_rst(rst0), .i_data_addr(a0), .i_data_wr_data(wd0),
      .i_data_mask(sz0), .i_data_wr_en(we0), .i_data_req(req0),
      .o_data_rd_data(rd0), .o_data_ack(ack0), .o_busy(busy0)
`ifdef DMEM_ERR_EN
      , .o_data_err(err0)
`endif
   );

   core_dmem_responder #(.XLEN(32), .DEPTH(DEPTH), .LATENCY(3)) dut3 (
      .i_clk(clk), .i_rst(rst3), .i_data_addr(a3), .i_data_wr_data(wd3),
      .i_data_mask(sz3), .i_data_wr_en(we3), .i_data_req(req3),
      .o_data_rd_data(rd3), .o_data_ack(ack3), .o_busy(busy3)
`ifdef DMEM_ERR_EN
      , .o_data_err(err3)
`endif
   );

   // Reference model: flat byte memory per instance, expected held read value
   logic [7:0]  mdl [2][NBYTES];
   logic [31:0] exp_rd [2];
   logic        exp_err [2];
   int n_chk = 0;
   int n_pass = 0;

   function automatic void model_op(input int d, input logic [31:0] a, input logic [31:0] wd,
                                    input logic [1:0] sz, input logic we);
      int unsigned n;
      logic [31:0] base;
      logic [31:0] r;
      n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      base = a - (a % n);
      exp_err[d] = 1'b0;
`ifdef DMEM_ERR_EN
      exp_err[d] = ((a % n) != 0) || (a >= NBYTES);
`endif
      if (exp_err[d]) begin
         exp_rd[d] = 32'h0;
      end else if (we) begin
         for (int unsigned i = 0; i < n; i++) mdl[d][(base + i) % NBYTES] = wd[8*i +: 8];
      end else begin
         r = 32'h0;
         for (int unsigned i = 0; i < n; i++) r[8*i +: 8] = mdl[d][(base + i) % NBYTES];
         exp_rd[d] = r;
      end
   endfunction

   function automatic logic [31:0] rand_addr();
`ifdef DMEM_ERR_EN
      if ($urandom_range(0, 7) == 0) return $urandom;
      return 32'($urandom_range(0, NBYTES - 1));
`else
      if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 63));
      return $urandom;
`endif
   endfunction

   // One cycle on the zero-latency instance; the model is applied on the sampling edge
   task automatic cyc0(input logic req, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic we);
      @(negedge clk);
      req0 = req; a0 = a; wd0 = wd; sz0 = sz; we0 = we;
      @(posedge clk);
      if (req) model_op(0, a, wd, sz, we);
      #1;
   endtask

   task automatic test_reset;
      rst0 = 1'b1; rst3 = 1'b1;
      req0 = 1'b0; we0 = 1'b0; sz0 = 2'd0; a0 = 32'h0; wd0 = 32'h0;
      req3 = 1'b0; we3 = 1'b0; sz3 = 2'd0; a3 = 32'h0; wd3 = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      n_chk++; if (ack0 !== 1'b0) $display("FAIL reset_ack0 got %b exp 0", ack0); else n_pass++;
      n_chk++; if (rd0 !== 32'h0) $display("FAIL reset_rd0 got %h exp 0", rd0); else n_pass++;
      n_chk++; if (busy0 !== 1'b0) $display("FAIL reset_busy0 got %b exp 0", busy0); else n_pass++;
      n_chk++; if (ack3 !== 1'b0) $display("FAIL reset_ack3 got %b exp 0", ack3); else n_pass++;
      n_chk++; if (rd3 !== 32'h0) $display("FAIL reset_rd3 got %h exp 0", rd3); else n_pass++;
      n_chk++; if (busy3 !== 1'b0) $display("FAIL reset_busy3 got %b exp 0", busy3); else n_pass++;
`ifdef DMEM_ERR_EN
      n_chk++; if (err0 !== 1'b0) $display("FAIL reset_err0 got %b exp 0", err0); else n_pass++;
      n_chk++; if (err3 !== 1'b0) $display("FAIL reset_err3 got %b exp 0", err3); else n_pass++;
`endif
      @(negedge clk);
      rst0 = 1'b0; rst3 = 1'b0;
      exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
      exp_err[0] = 1'b0; exp_err[1] = 1'b0;
   endtask

   // Fill dut0 with req held high: one ack per cycle is expected
   task automatic test_back_to_back;
      for (int w = 0; w < DEPTH; w++) begin
         cyc0(1'b1, 32'(w * 4), $urandom, 2'd2, 1'b1);
         n_chk++; if (ack0 !== 1'b1) $display("FAIL b2b_ack w=%0d got %b exp 1", w, ack0); else n_pass++;
      end
      cyc0(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
      n_chk++; if (ack0 !== 1'b0) $display("FAIL b2b_idle_ack got %b exp 0", ack0); else n_pass++;
   endtask

   // Fill dut3 one word at a time, waiting out the latency
   task automatic init_dut3;
      for (int w = 0; w < DEPTH; w++) begin
         @(negedge clk);
         req3 = 1'b1; a3 = 32'(w * 4); wd3 = $urandom; sz3 = 2'd2; we3 = 1'b1;
         @(posedge clk);
         model_op(1, a3, wd3, sz3, we3);
         @(negedge clk);
         req3 = 1'b0;
         repeat (3) @(posedge clk);
      end
   endtask

   task automatic test_directed;
      cyc0(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b1);
      n_chk++; if (ack0 !== 1'b1) $display("FAIL dir_wr_ack got %b exp 1", ack0); else n_pass++;
      cyc0(1'b1, 32'h10, 32'h0, 2'd2, 1'b0);
      n_chk++; if (ack0 !== 1'b1) $display("FAIL dir_rd_ack got %b exp 1", ack0); else n_pass++;
      n_chk++; if (rd0 !== 32'hDEADBEEF) $display("FAIL dir_rd_word got %h exp DEADBEEF", rd0); else n_pass++;
      cyc0(1'b1, 32'h13, 32'h123456AB, 2'd0, 1'b1);
      n_chk++; if (rd0 !== 32'hDEADBEEF) $display("FAIL dir_wr_holds_rd got %h exp DEADBEEF", rd0); else n_pass++;
      cyc0(1'b1, 32'h10, 32'h0, 2'd2, 1'b0);
      n_chk++; if (rd0 !== 32'hABADBEEF) $display("FAIL dir_rd_merged got %h exp ABADBEEF", rd0); else n_pass++;
      cyc0(1'b1, 32'h13, 32'h0, 2'd0, 1'b0);
      n_chk++; if (rd0 !== 32'h000000AB) $display("FAIL dir_rd_byte got %h exp 000000AB", rd0); else n_pass++;
      cyc0(1'b1, 32'h12, 32'h0, 2'd1, 1'b0);
      n_chk++; if (rd0 !== 32'h0000ABAD) $display("FAIL dir_rd_half got %h exp 0000ABAD", rd0); else n_pass++;
      cyc0(1'b1, 32'h13, 32'h0, 2'd1, 1'b0);
`ifdef DMEM_ERR_EN
      n_chk++; if (err0 !== 1'b1) $display("FAIL dir_mis_half_err got %b exp 1", err0); else n_pass++;
      n_chk++; if (rd0 !== 32'h0) $display("FAIL dir_mis_half_rd got %h exp 0", rd0); else n_pass++;
      cyc0(1'b1, 32'h11, 32'h55555555, 2'd2, 1'b1);
      n_chk++; if (err0 !== 1'b1) $display("FAIL dir_mis_word_err got %b exp 1", err0); else n_pass++;
      cyc0(1'b1, 32'h10, 32'h0, 2'd2, 1'b0);
      n_chk++; if (rd0 !== 32'hABADBEEF) $display("FAIL dir_mis_wr_no_land got %h exp ABADBEEF", rd0); else n_pass++;
      cyc0(1'b1, 32'(NBYTES), 32'h0, 2'd2, 1'b0);
      n_chk++; if (err0 !== 1'b1) $display("FAIL dir_oor_err got %b exp 1", err0); else n_pass++;
      n_chk++; if (rd0 !== 32'h0) $display("FAIL dir_oor_rd got %h exp 0", rd0); else n_pass++;
`else
      n_chk++; if (rd0 !== 32'h0000ABAD) $display("FAIL dir_rd_half_forced got %h exp 0000ABAD", rd0); else n_pass++;
      cyc0(1'b1, 32'(NBYTES + 32'h10), 32'h0, 2'd2, 1'b0);
      n_chk++; if (rd0 !== 32'hABADBEEF) $display("FAIL dir_wrap got %h exp ABADBEEF", rd0); else n_pass++;
`endif
      cyc0(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
      n_chk++; if (ack0 !== 1'b0) $display("FAIL dir_idle_ack got %b exp 0", ack0); else n_pass++;
   endtask

   task automatic test_random_lat0;
      logic        req, we;
      logic [1:0]  sz;
      logic [31:0] a, wd;
      for (int k = 0; k < 300; k++) begin
         req = ($urandom_range(0, 3) != 0);
         a = rand_addr(); wd = $urandom;
         sz = 2'($urandom_range(0, 3)); we = 1'($urandom_range(0, 1));
         cyc0(req, a, wd, sz, we);
         n_chk++; if (ack0 !== req) $display("FAIL r0_ack k=%0d got %b exp %b", k, ack0, req); else n_pass++;
         n_chk++; if (rd0 !== exp_rd[0]) $display("FAIL r0_rd k=%0d got %h exp %h", k, rd0, exp_rd[0]); else n_pass++;
         n_chk++; if (busy0 !== 1'b0) $display("FAIL r0_busy k=%0d got %b exp 0", k, busy0); else n_pass++;
`ifdef DMEM_ERR_EN
         if (req) begin
            n_chk++; if (err0 !== exp_err[0]) $display("FAIL r0_err k=%0d got %b exp %b", k, err0, exp_err[0]); else n_pass++;
         end
`endif
      end
      cyc0(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
   endtask

   // LATENCY=3: ack exactly 4 edges after accept, requests during WAIT ignored,
   // the next request accepted in the ack cycle
   task automatic test_wait_states;
      @(negedge clk);
      req3 = 1'b1; a3 = rand_addr(); wd3 = $urandom;
      sz3 = 2'($urandom_range(0, 3)); we3 = 1'($urandom_range(0, 1));
      @(posedge clk);
      model_op(1, a3, wd3, sz3, we3);
      #1;
      for (int k = 0; k < 40; k++) begin
         for (int c = 1; c <= 3; c++) begin
            n_chk++; if ({ack3, busy3} !== 2'b01)
               $display("FAIL lat_wait k=%0d c=%0d got ack/busy %b exp 01", k, c, {ack3, busy3}); else n_pass++;
            @(negedge clk);
            req3 = 1'($urandom_range(0, 1)); a3 = rand_addr(); wd3 = $urandom;
            sz3 = 2'($urandom_range(0, 3)); we3 = 1'b1;
            @(posedge clk);
            #1;
         end
         n_chk++; if ({ack3, busy3} !== 2'b10)
            $display("FAIL lat_ack k=%0d got ack/busy %b exp 10", k, {ack3, busy3}); else n_pass++;
         n_chk++; if (rd3 !== exp_rd[1]) $display("FAIL lat_rd k=%0d got %h exp %h", k, rd3, exp_rd[1]); else n_pass++;
`ifdef DMEM_ERR_EN
         n_chk++; if (err3 !== exp_err[1]) $display("FAIL lat_err k=%0d got %b exp %b", k, err3, exp_err[1]); else n_pass++;
`endif
         @(negedge clk);
         if (k < 39) begin
            req3 = 1'b1; a3 = rand_addr(); wd3 = $urandom;
            sz3 = 2'($urandom_range(0, 3)); we3 = 1'($urandom_range(0, 1));
            @(posedge clk);
            model_op(1, a3, wd3, sz3, we3);
            #1;
         end else begin
            req3 = 1'b0;
            @(posedge clk);
            #1;
            n_chk++; if (ack3 !== 1'b0) $display("FAIL lat_end_ack got %b exp 0", ack3); else n_pass++;
         end
      end
   endtask

   // Reset during WAIT drops the pending write
   task automatic test_reset_mid_wait;
      @(negedge clk);
      req3 = 1'b1; a3 = 32'h20; wd3 = 32'h1; sz3 = 2'd2; we3 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req3 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst3 = 1'b1;
      @(posedge clk);
      exp_rd[1] = 32'h0;
      #1;
      n_chk++; if (rd3 !== 32'h0) $display("FAIL rstw_rd got %h exp 0", rd3); else n_pass++;
      n_chk++; if (busy3 !== 1'b0) $display("FAIL rstw_busy got %b exp 0", busy3); else n_pass++;
      @(negedge clk);
      rst3 = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         n_chk++; if (ack3 !== 1'b0) $display("FAIL rstw_no_ack c=%0d got %b exp 0", c, ack3); else n_pass++;
      end
      @(negedge clk);
      req3 = 1'b1; a3 = 32'h20; sz3 = 2'd2; we3 = 1'b0;
      @(posedge clk);
      model_op(1, a3, wd3, sz3, we3);
      @(negedge clk);
      req3 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_chk++; if (ack3 !== 1'b1) $display("FAIL rstw_read_ack got %b exp 1", ack3); else n_pass++;
      n_chk++; if (rd3 !== exp_rd[1]) $display("FAIL rstw_old_value got %h exp %h", rd3, exp_rd[1]); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      init_dut3();
      test_directed();
      test_random_lat0();
      test_wait_states();
      test_reset_mid_wait();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
